// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier with valid/ready on both sides.
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [PW-1:0]    mcand_reg;
    logic [PW-1:0]    acc_reg;
    logic [PW-1:0]    product_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    cnt_reg;

    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    mcand_step;
    logic [WIDTH-1:0] mplier_step;
    logic [CW-1:0]    cnt_step;
    logic             last_step;
    logic             skip_run;

    // One shift-and-add iteration, evaluated from the current RUN registers.
    always_comb begin
        acc_step    = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        mcand_step  = mcand_reg << 1;
        mplier_step = mplier_reg >> 1;
        cnt_step    = cnt_reg + CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_step   = (cnt_step == CW'(WIDTH)) || (mplier_step == '0);
        skip_run    = (b == '0);
`else
        last_step   = (cnt_step == CW'(WIDTH));
        skip_run    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = skip_run ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode state only, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, a};
                        mplier_reg <= b;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        if (skip_run) begin
                            product_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    acc_reg    <= acc_step;
                    mcand_reg  <= mcand_step;
                    mplier_reg <= mplier_step;
                    cnt_reg    <= cnt_step;
                    if (last_step) begin
                        product_reg <= acc_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = product_reg;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult (WIDTH=4); expected latencies follow
// whichever build SEQ_MULT_EARLY_TERM_EN selects.
module tb_seq_shift_add_mult;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shift_add_mult #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One operation: accept, measure latency (accept edge counts as 1), optional
    // back-pressure hold, optional ignored operands while busy, then transfer.
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp_p,
                          input int lat_nom, input int lat_et, input int hold, input bit noise);
        int lat;
        int exp_lat;
`ifdef SEQ_MULT_EARLY_TERM_EN
        exp_lat = lat_et;
`else
        exp_lat = lat_nom;
`endif
        @(negedge clk);
        a         = ai;
        b         = bi;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        if (noise) begin
            a = 4'd3;
            b = 4'd3;
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (hold == 0) in_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("out_valid", out_valid, 1);
        chk("product", product, exp_p);
        chk("in_ready_busy", in_ready, 0);
        chk("busy", busy, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_product", product, exp_p);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_product_held", product, exp_p);
        $display("op a=%0d b=%0d product=%0d latency=%0d hold=%0d noise=%0d", ai, bi, product, lat, hold, noise);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //     a      b      prod    nom et hold noise
        run_op(4'd15, 4'd15, 8'd225, 5, 5, 0, 0);
        run_op(4'd9,  4'd0,  8'd0,   5, 1, 0, 0);
        run_op(4'd8,  4'd2,  8'd16,  5, 3, 0, 0);
        run_op(4'd1,  4'd1,  8'd1,   5, 2, 0, 0);
        run_op(4'd0,  4'd15, 8'd0,   5, 5, 0, 0);
        run_op(4'd6,  4'd3,  8'd18,  5, 3, 0, 1);
        run_op(4'd7,  4'd5,  8'd35,  5, 4, 10, 1);

        // Asynchronous reset two RUN edges into 12*11.
        @(negedge clk);
        a         = 4'd12;
        b         = 4'd11;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_product", product, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_busy", busy, 0);
        $display("reset mid-run product=%0d in_ready=%0d", product, in_ready);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd12, 4'd11, 8'd132, 5, 5, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
